// File: rtl/branch_defs_pkg.sv
// Shared definitions for the branch sequencer: condition codes, FSM state
// encoding and PC arithmetic constants.
package branch_defs;

  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_NE = 2'b01;
  localparam logic [1:0] COND_LT = 2'b10;
  localparam logic [1:0] COND_LE = 2'b11;

  localparam int unsigned PC_INCR     = 4;
  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WAIT_OPND = 2'b01,
    S_RESOLVE   = 2'b10,
    S_FLUSH     = 2'b11
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator; all compares are unsigned.
module branch_cond_eval
  import branch_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       cond_i,
  input  logic [WIDTH-1:0] rd1_i,
  input  logic [WIDTH-1:0] rd2_i,
  output logic             taken_o
);

  always_comb begin
    // NOTE: default first so every path assigns taken_o and no latch is inferred.
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = (rd1_i == rd2_i);
      COND_NE: taken_o = (rd1_i != rd2_i);
      COND_LT: taken_o = (rd1_i <  rd2_i);
      COND_LE: taken_o = (rd1_i <= rd2_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Holds one decoded branch until its operands arrive, resolves it, and issues
// a redirect pulse plus a fixed-length flush when taken. Outputs are registered.
module branch_sequencer
  import branch_defs::*;
#(
  parameter int WIDTH        = 32,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [1:0]          br_cond,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic [15:0]         br_offset,
  input  logic                opnd_valid,
  input  logic [WIDTH-1:0]    rd1,
  input  logic [WIDTH-1:0]    rd2,
  output logic                stall_fetch,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic [15:0]         branch_count,
  output logic [15:0]         taken_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_e                 state_q;
  logic [1:0]             cond_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [15:0]            off_q;
  logic                   taken_q;
  logic [PC_WIDTH-1:0]    target_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic [15:0]            branch_cnt_q, branch_cnt_d;
  logic [15:0]            taken_cnt_q, taken_cnt_d;
  logic                   br_ready_q, stall_q, redirect_valid_q, flush_q;

  logic                   taken_d;
  logic [PC_WIDTH-1:0]    off_ext;
  logic [PC_WIDTH-1:0]    target_d;

  branch_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .cond_i  (cond_q),
    .rd1_i   (rd1),
    .rd2_i   (rd2),
    .taken_o (taken_d)
  );

  // Word offset: sign-extend, scale by 4; the sum wraps modulo 2^PC_WIDTH.
  assign off_ext  = {{(PC_WIDTH-16){off_q[15]}}, off_q} << 2;
  assign target_d = pc_q + PC_WIDTH'(PC_INCR) + off_ext;

  always_comb begin
    branch_cnt_d = (branch_cnt_q == 16'hFFFF) ? branch_cnt_q : branch_cnt_q + 16'd1;
    taken_cnt_d  = (taken_q && taken_cnt_q != 16'hFFFF) ? taken_cnt_q + 16'd1 : taken_cnt_q;
  end

  // Output registers are loaded with the values of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cond_q           <= COND_EQ;
      pc_q             <= '0;
      off_q            <= '0;
      taken_q          <= 1'b0;
      target_q         <= '0;
      flush_cnt_q      <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
      br_ready_q       <= 1'b1;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (br_valid) begin
            cond_q     <= br_cond;
            pc_q       <= br_pc;
            off_q      <= br_offset;
            state_q    <= S_WAIT_OPND;
            br_ready_q <= 1'b0;
            stall_q    <= 1'b1;
          end
        end
        S_WAIT_OPND: begin
          if (opnd_valid) begin
            taken_q          <= taken_d;
            target_q         <= target_d;
            redirect_valid_q <= taken_d;
            state_q          <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          branch_cnt_q <= branch_cnt_d;
          taken_cnt_q  <= taken_cnt_d;
          stall_q      <= 1'b0;
          if (taken_q) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
            flush_q     <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            br_ready_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 1'b1;
          if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
            state_q    <= S_IDLE;
            flush_q    <= 1'b0;
            br_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign br_ready       = br_ready_q;
  assign stall_fetch    = stall_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;
  assign flush          = flush_q;
  assign branch_count   = branch_cnt_q;
  assign taken_count    = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: cycle-exact handshake, redirect, flush
// and statistics checks against hand-computed expectations.
module tb_branch_sequencer;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic        br_ready;
  logic [1:0]  br_cond;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic        opnd_valid;
  logic [31:0] rd1, rd2;
  logic        stall_fetch, redirect_valid, flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, taken_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_br_cnt = '0;
  logic [15:0] exp_tk_cnt = '0;

  branch_sequencer #(
    .WIDTH(32), .PC_WIDTH(32), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_offset(br_offset),
    .opnd_valid(opnd_valid), .rd1(rd1), .rd2(rd2),
    .stall_fetch(stall_fetch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, ".branch_count"}, {16'd0, branch_count}, {16'd0, exp_br_cnt});
    check({tag, ".taken_count"},  {16'd0, taken_count},  {16'd0, exp_tk_cnt});
  endtask

  // Drives one branch from IDLE and checks every cycle until IDLE again.
  task automatic run_branch(input string tag, input logic [1:0] c, input logic [31:0] pc,
                            input logic [15:0] off, input logic [31:0] a, input logic [31:0] b,
                            input int wait_cycles, input bit pulse, input bit hold,
                            input bit exp_taken, input logic [31:0] exp_pc);
    br_valid  = 1'b1;
    br_cond   = c;
    br_pc     = pc;
    br_offset = off;
    step();
    if (!hold) br_valid = 1'b0;
    check({tag, ".accept_ready"}, {31'd0, br_ready}, 32'd0);
    check({tag, ".accept_stall"}, {31'd0, stall_fetch}, 32'd1);
    for (int i = 0; i < wait_cycles; i++) begin
      if (pulse) br_valid = ~br_valid;
      step();
      check({tag, ".wait_stall"}, {31'd0, stall_fetch}, 32'd1);
      check({tag, ".wait_ready"}, {31'd0, br_ready}, 32'd0);
      check({tag, ".wait_redir"}, {31'd0, redirect_valid}, 32'd0);
    end
    if (!hold) br_valid = 1'b0;
    opnd_valid = 1'b1;
    rd1 = a;
    rd2 = b;
    step();
    opnd_valid = 1'b0;
    rd1 = 32'hDEAD_BEEF;
    rd2 = 32'h0BAD_F00D;
    check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, exp_taken});
    check({tag, ".redirect_pc"}, redirect_pc, exp_pc);
    check({tag, ".resolve_stall"}, {31'd0, stall_fetch}, 32'd1);
    exp_br_cnt = sat_inc(exp_br_cnt);
    if (exp_taken) exp_tk_cnt = sat_inc(exp_tk_cnt);
    step();
    if (exp_taken) begin
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
        check({tag, ".flush"}, {31'd0, flush}, 32'd1);
        check({tag, ".flush_stall"}, {31'd0, stall_fetch}, 32'd0);
        check({tag, ".flush_redir"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, ".flush_ready"}, {31'd0, br_ready}, 32'd0);
        step();
      end
    end
    check({tag, ".idle_ready"}, {31'd0, br_ready}, 32'd1);
    check({tag, ".idle_flush"}, {31'd0, flush}, 32'd0);
    check({tag, ".idle_stall"}, {31'd0, stall_fetch}, 32'd0);
    check({tag, ".idle_redir"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, ".redirect_pc_hold"}, redirect_pc, exp_pc);
    check_counts(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; br_valid = 1'b0; br_cond = 2'b00; br_pc = '0; br_offset = '0;
    opnd_valid = 1'b0; rd1 = '0; rd2 = '0;
    step();
    step();
    reset = 1'b0;
    check("rst.br_ready", {31'd0, br_ready}, 32'd1);
    check("rst.stall", {31'd0, stall_fetch}, 32'd0);
    check("rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst.flush", {31'd0, flush}, 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'd0);
    check_counts("rst");

    // Taken eq: 0x100 + 4 + 3*4 = 0x110
    run_branch("eq_taken", 2'b00, 32'h100, 16'h0003, 32'd5, 32'd5, 0, 0, 0, 1'b1, 32'h110);
    // Unsigned compares
    run_branch("lt_unsigned", 2'b10, 32'h200, 16'h0010, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1'b0, 32'h244);
    run_branch("le_equal", 2'b11, 32'h300, 16'hFFFC, 32'd7, 32'd7, 0, 0, 0, 1'b1, 32'h2F4);
    run_branch("ne_equal", 2'b01, 32'h400, 16'h0001, 32'd9, 32'd9, 0, 0, 0, 1'b0, 32'h408);
    run_branch("lt_true", 2'b10, 32'h500, 16'h0000, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 1'b1, 32'h504);
    run_branch("ne_true", 2'b01, 32'h600, 16'h0002, 32'd3, 32'd4, 0, 0, 0, 1'b1, 32'h60C);
    run_branch("le_greater", 2'b11, 32'h700, 16'h0002, 32'd8, 32'd7, 0, 0, 0, 1'b0, 32'h70C);
    // Offset wrap-around
    run_branch("wrap_m1", 2'b00, 32'h0, 16'hFFFF, 32'd1, 32'd1, 0, 0, 0, 1'b1, 32'h0);
    run_branch("wrap_m2", 2'b00, 32'h0, 16'hFFFE, 32'd1, 32'd1, 0, 0, 0, 1'b1, 32'hFFFF_FFFC);
    run_branch("wrap_top", 2'b00, 32'hFFFF_FFFC, 16'h0000, 32'd1, 32'd1, 0, 0, 0, 1'b1, 32'h0);
    // Operand wait with stray br_valid pulses
    run_branch("opnd_wait", 2'b00, 32'h800, 16'h0004, 32'd2, 32'd2, 3, 1, 0, 1'b1, 32'h814);
    // Back-to-back with br_valid held high: second accept on the first IDLE cycle
    run_branch("b2b_first", 2'b00, 32'h900, 16'h0001, 32'd0, 32'd0, 0, 0, 1, 1'b1, 32'h908);
    run_branch("b2b_second", 2'b11, 32'hA00, 16'h0001, 32'd0, 32'd6, 0, 0, 1, 1'b1, 32'hA08);
    br_valid = 1'b0;
    step();
    check("b2b.idle_ready", {31'd0, br_ready}, 32'd1);

    // Reset during the first flush cycle
    br_valid = 1'b1; br_cond = 2'b00; br_pc = 32'hB00; br_offset = 16'h0005;
    step();
    br_valid = 1'b0;
    opnd_valid = 1'b1; rd1 = 32'd1; rd2 = 32'd1;
    step();
    opnd_valid = 1'b0;
    check("midrst.redirect_valid", {31'd0, redirect_valid}, 32'd1);
    step();
    check("midrst.flush_before", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_br_cnt = '0;
    exp_tk_cnt = '0;
    check("midrst.flush", {31'd0, flush}, 32'd0);
    check("midrst.br_ready", {31'd0, br_ready}, 32'd1);
    check("midrst.redirect_pc", redirect_pc, 32'd0);
    check_counts("midrst");
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst.no_redirect", {31'd0, redirect_valid}, 32'd0);
      check("midrst.no_flush", {31'd0, flush}, 32'd0);
    end

    // Saturation: preload both counters one below the limit
    force dut.branch_cnt_q = 16'hFFFE;
    force dut.taken_cnt_q  = 16'hFFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
    exp_br_cnt = 16'hFFFE;
    exp_tk_cnt = 16'hFFFE;
    check_counts("sat_preload");
    run_branch("sat_1", 2'b00, 32'hC00, 16'h0000, 32'd4, 32'd4, 0, 0, 0, 1'b1, 32'hC04);
    run_branch("sat_2", 2'b00, 32'hC00, 16'h0000, 32'd4, 32'd4, 0, 0, 0, 1'b1, 32'hC04);
    run_branch("sat_3", 2'b01, 32'hC00, 16'h0000, 32'd4, 32'd4, 0, 0, 0, 1'b0, 32'hC04);
    check("sat.branch_final", {16'd0, branch_count}, 32'h0000_FFFF);
    check("sat.taken_final", {16'd0, taken_count}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
